// File: rtl/uart_tx_arbiter_if.sv
// Byte-request and UART Tx bus shared by uart_tx_arbiter and its environment.
// Requesters and the Tx instance sit on the master side; the arbiter is the slave.
//
// Handshake: req_valid[i] is raised with req_data[8*i+7:8*i] and held until the arbiter
// answers with a one-cycle req_ready[i]; the byte is taken on that cycle's rising edge.
// req_valid may be dropped before req_ready to withdraw the request. tx_send is held
// until tx_busy is seen high. tx_data is stable from capture until tx_done, and tx_done
// is a one-cycle completion pulse.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               tx_send;
    logic [7:0]         tx_data;
    logic               tx_busy;
    logic               tx_done;

    modport slave (
        input  req_valid, req_data, tx_busy, tx_done,
        output req_ready, tx_send, tx_data
    );

    modport master (
        output req_valid, req_data, tx_busy, tx_done,
        input  req_ready, tx_send, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one 8N1 UART transmitter between N_REQ byte
// requesters. One byte is captured per grant, handed to the Tx, and followed by an idle
// gap of GAP_BITS bit-times after tx_done.
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to abandon a byte whose tx_done does
// not arrive within TIMEOUT_CYCLES clocks of SEND entry (timeout_err pulses once).
// dbg_state exposes the FSM state: 0 IDLE, 1 SEND, 2 WAIT, 3 GAP.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int CLK_FREQ       = 50000000,
    parameter int BAUDRATE       = 9600,
    parameter int TICK_PER_BIT   = CLK_FREQ / BAUDRATE,
    parameter int GAP_BITS       = 1,
    parameter int TIMEOUT_CYCLES = 12 * TICK_PER_BIT,
    localparam int IDW           = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus,
    output logic [IDW-1:0]   grant_id,
    output logic             active,
    output logic             timeout_err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } state_e;

    // GAP_BITS = 0 still spends one clock in GAP, so the load value floors at zero.
    localparam int GAP_TOTAL = GAP_BITS * TICK_PER_BIT;
    localparam int GAP_LOAD  = (GAP_TOTAL > 0) ? GAP_TOTAL - 1 : 0;
    localparam int GAP_W     = (GAP_LOAD > 0) ? $clog2(GAP_LOAD + 1) : 1;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
    end

    state_e             r_state;
    state_e             w_next;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_grant_id;
    logic [N_REQ-1:0]   r_req_ready;
    logic [7:0]         r_tx_data;
    logic [IDW-1:0]     w_win;
    logic [IDW-1:0]     w_idx;
    logic [IDW:0]       w_sum;
    logic [IDW-1:0]     w_rr_next;
    logic               w_found;
    logic               w_grant;
    logic               w_to_fire;

    // Winner search: first pending requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW + 1)'(k);
            if (w_sum >= (IDW + 1)'(N_REQ)) begin
                w_sum = w_sum - (IDW + 1)'(N_REQ);
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        w_rr_next = (w_win == IDW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
    end

    // A grant needs an idle arbiter, a pending request and an idle transmitter.
    assign w_grant = (r_state == S_IDLE) && w_found && !bus.tx_busy;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_err;

    // Fires on the clock where TIMEOUT_CYCLES clocks have passed since SEND entry with no tx_done.
    assign w_to_fire = ((r_state == S_SEND) || (r_state == S_WAIT)) && !bus.tx_done &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Timeout counter runs only while a byte is owned by the Tx; error is a one-clock pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_to_fire;
            if (w_grant) begin
                r_to_cnt <= '0;
            end else if ((r_state == S_SEND) || (r_state == S_WAIT)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_to_fire   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a tx_done that beats the busy handshake still completes the byte.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_grant) w_next = S_SEND;
            S_SEND: begin
                if (w_to_fire || bus.tx_done) begin
                    w_next = S_GAP;
                end else if (bus.tx_busy) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: if (w_to_fire || bus.tx_done) w_next = S_GAP;
            S_GAP:  if (r_gap_cnt == '0) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Capture the winner's byte, issue its ready pulse and advance the pointer on each grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_ready <= '0;
            r_tx_data   <= 8'h00;
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_req_ready <= '0;
            if (w_grant) begin
                r_req_ready <= N_REQ'(1) << w_win;
                r_tx_data   <= bus.req_data[{w_win, 3'b000} +: 8];
                r_grant_id  <= w_win;
                r_rr_ptr    <= w_rr_next;
            end
        end
    end

    // Inter-byte gap: loaded on GAP entry, counted down to zero while in GAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gap_cnt <= '0;
        end else if ((w_next == S_GAP) && (r_state != S_GAP)) begin
            r_gap_cnt <= GAP_W'(GAP_LOAD);
        end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.tx_send   = (r_state == S_SEND);
    assign bus.tx_data   = r_tx_data;
    assign grant_id      = r_grant_id;
    assign active        = (r_state != S_IDLE);
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural 8N1 Tx stub, a serial-line receiver and a
// grant scoreboard. Runs at 8 clocks per bit so whole frames fit a short simulation.
module tb_uart_tx_arbiter;

    localparam int N_REQ    = 4;
    localparam int CLK_FREQ = 800;
    localparam int BAUDRATE = 100;
    localparam int TICK     = CLK_FREQ / BAUDRATE;
    localparam int GAP_BITS = 1;
    localparam int TIMEOUT  = 100;
    localparam int GAP_CLKS = GAP_BITS * TICK;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] grant_id;
    logic       active;
    logic       timeout_err;
    logic [1:0] dbg_state;
    logic       line = 1'b1;

    uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus();

    uart_tx_arbiter #(
        .N_REQ          (N_REQ),
        .CLK_FREQ       (CLK_FREQ),
        .BAUDRATE       (BAUDRATE),
        .GAP_BITS       (GAP_BITS),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int to_pulses = 0;

    logic [9:0] exp_q[$];
    logic [7:0] line_q[$];

    bit         stub_force_busy = 1'b0;
    bit         stub_no_done    = 1'b0;
    logic [7:0] stub_b;
    logic [7:0] rx_b;
    logic [9:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Tx stub: accepts tx_send when idle, shifts an 8N1 frame onto line, pulses tx_done.
    task automatic stub_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        forever begin
            stub_wait(1);
            if (stub_force_busy) begin
                bus.tx_busy = 1'b1;
            end else if (bus.tx_send) begin
                stub_b      = bus.tx_data;
                bus.tx_busy = 1'b1;
                line        = 1'b0;
                stub_wait(TICK);
                for (int i = 0; i < 8; i++) begin
                    line = stub_b[i];
                    stub_wait(TICK);
                end
                line = 1'b1;
                stub_wait(TICK - 1);
                if (!stub_no_done) bus.tx_done = 1'b1;
                stub_wait(1);
                bus.tx_done = 1'b0;
                bus.tx_busy = 1'b0;
            end else begin
                bus.tx_busy = 1'b0;
            end
        end
    end

    // Serial receiver: rebuilds each frame mid-bit and checks it against line_q.
    initial begin
        forever begin
            @(negedge clk);
            if (line === 1'b0) begin
                repeat (TICK / 2) @(negedge clk);
                check("rx_start", line, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (TICK) @(negedge clk);
                    rx_b[i] = line;
                end
                repeat (TICK) @(negedge clk);
                check("rx_stop", line, 1'b1);
                if (line_q.size() == 0) fail_now("rx_unexpected_byte");
                else check("rx_byte", rx_b, line_q.pop_front());
            end
        end
    end

    // Grant monitor: every req_ready pulse is matched against the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (timeout_err === 1'b1) to_pulses++;
            if (bus.req_ready !== '0) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_grant");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ready_onehot", bus.req_ready, 4'b0001 << mon_e[9:8]);
                    check("grant_id", grant_id, mon_e[9:8]);
                    check("tx_data", bus.tx_data, mon_e[7:0]);
                end
            end
        end
    end

    // Driver tasks (all called at a falling edge)
    task automatic issue(input int id, input logic [7:0] d);
        exp_q.push_back({id[1:0], d});
        line_q.push_back(d);
        bus.req_data[8*id +: 8] = d;
        bus.req_valid[id]       = 1'b1;
    endtask

    task automatic wait_ready(input int id);
        int n = 0;
        while (bus.req_ready[id] !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail_now("wait_ready_timeout");
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.tx_done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail_now("wait_done_timeout");
    endtask

    task automatic wait_idle();
        int n = 0;
        while (active !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail_now("wait_idle_timeout");
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int  n;
    int  left;
    int  t_done;
    int  t_send;
    bit  have_done;
    bit  prev_send;
    bit  r0_again;

    initial begin
        // 1: reset held with every request pending
        bus.req_valid = 4'hF;
        bus.req_data  = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 4'b0000);
        check("rst_tx_send", bus.tx_send, 1'b0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_grant_id", grant_id, 2'd0);
        check("rst_active", active, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        bus.req_valid = '0;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 2: single byte from requester 2
        issue(2, 8'h55);
        @(negedge clk);
        check("lat_tx_send", bus.tx_send, 1'b1);
        check("lat_req_ready", bus.req_ready, 4'b0100);
        wait_ready(2);
        @(negedge clk);
        check("single_ready_pulse", bus.req_ready, 4'b0000);
        wait_done();
        check("tx_data_stable", bus.tx_data, 8'h55);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (active && n < 100);
        check("done_to_idle", n, GAP_CLKS + 1);

        // 3: round robin from a fresh pointer, all requesters held
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) issue(i, 8'hA0 + 8'(i));
        left = 5; r0_again = 1'b1; have_done = 1'b0; prev_send = 1'b0; n = 0;
        while (left > 0 && n < 2000) begin
            @(negedge clk);
            n++;
            if (bus.tx_done === 1'b1) begin
                t_done    = cyc;
                have_done = 1'b1;
            end
            if (bus.tx_send && !prev_send && have_done) begin
                check("rr_gap", cyc - t_done, GAP_CLKS + 2);
                have_done = 1'b0;
            end
            prev_send = bus.tx_send;
            for (int i = 0; i < 4; i++) begin
                if (bus.req_ready[i] === 1'b1) begin
                    left--;
                    if (i == 0 && r0_again) begin
                        r0_again = 1'b0;
                        exp_q.push_back({2'd0, 8'hA4});
                        line_q.push_back(8'hA4);
                        bus.req_data[7:0] = 8'hA4;
                    end else begin
                        bus.req_valid[i] = 1'b0;
                    end
                end
            end
        end
        if (left > 0) fail_now("rr_budget");
        wait_done();
        wait_idle();

        // 4: transmitter busy holds off the grant
        stub_force_busy = 1'b1;
        repeat (2) @(negedge clk);
        issue(0, 8'h3C);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.req_ready !== '0) n++;
        end
        check("busy_no_grant", n, 0);
        stub_force_busy = 1'b0;
        @(negedge clk);
        check("busy_released", bus.tx_busy, 1'b0);
        @(negedge clk);
        check("busy_grant", bus.req_ready, 4'b0001);
        wait_ready(0);
        wait_done();
        wait_idle();

        // 5: reset while waiting for the Tx
        issue(1, 8'h96);
        wait_ready(1);
        n = 0;
        while (dbg_state !== 2'd2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_wait", dbg_state, 2'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx_send", bus.tx_send, 1'b0);
        check("midrst_active", active, 1'b0);
        check("midrst_state", dbg_state, 2'd0);
        issue(0, 8'h0F);
        issue(3, 8'hC3);
        wait_ready(0);
        wait_ready(3);
        wait_done();
        wait_idle();

        // 6: Tx never reports done
        stub_no_done = 1'b1;
        issue(2, 8'hE1);
        wait_ready(2);
        t_send = cyc;
`ifdef UART_TX_ARB_TIMEOUT_EN
        n = 0;
        while (timeout_err !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", cyc - t_send, TIMEOUT);
        check("timeout_to_gap", dbg_state, 2'd3);
        wait_idle();
        check("timeout_idle", dbg_state, 2'd0);
        check("timeout_pulses", to_pulses, 1);
`else
        repeat (150) @(negedge clk);
        check("no_timeout_state", dbg_state, 2'd2);
        check("no_timeout_err", to_pulses, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
        n = 0;
        while (bus.tx_busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        stub_no_done = 1'b0;

        // Drain and report
        repeat (TICK * 12) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("line_q_empty", line_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
